// File: rtl/ray_pixel_scheduler_pkg.sv
// Shared screen geometry, colour width and scheduler state encodings.
package ray_pixel_scheduler_pkg;

   localparam int unsigned SCREEN_WIDTH  = 640;
   localparam int unsigned SCREEN_HEIGHT = 480;
   localparam int unsigned COLOR_WIDTH   = 8;

   // Coordinate port widths sized for the default 640x480 raster.
   localparam int unsigned X_W = 10;
   localparam int unsigned Y_W = 9;

   typedef logic [1:0] sched_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ray_pixel_scheduler_fifo.sv
// Synchronous result FIFO with a registered head word.
module pix_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_nxt_c;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    remain_c;
   logic [WIDTH-1:0] head_q;
   logic             wr_en_c;
   logic             rd_en_c;

   // A write into a full FIFO is only accepted if the head leaves the same cycle.
   assign rd_en_c      = pop & (count_q != '0);
   assign wr_en_c      = push & ((count_q != CW'(DEPTH)) | rd_en_c);
   assign rd_ptr_nxt_c = rd_ptr_q + AW'(rd_en_c);
   assign remain_c     = count_q - CW'(rd_en_c);

   assign head  = head_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= din;
   end

   // Pointers, occupancy and the registered head word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (wr_en_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         rd_ptr_q <= rd_ptr_nxt_c;
         count_q  <= remain_c + CW'(wr_en_c);
         // Head follows the next stored entry, or the incoming word when nothing else is left.
         if ((rd_en_c || (count_q == '0)) && ((remain_c != '0) || wr_en_c))
            head_q <= (remain_c == '0) ? din : mem_q[rd_ptr_nxt_c];
      end
   end

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Frame sequencer: issues raster coordinates under credit control and streams results to the packer.
module ray_pixel_scheduler
   import ray_pixel_scheduler_pkg::*;
#(
   parameter int unsigned SCREEN_W   = SCREEN_WIDTH,
   parameter int unsigned SCREEN_H   = SCREEN_HEIGHT,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned COLOR_W    = COLOR_WIDTH
) (
   input  logic                 out_stream_aclk,
   input  logic                 periph_resetn,
   input  logic                 enable,
   output logic [X_W-1:0]       issue_x,
   output logic [Y_W-1:0]       issue_y,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   input  logic                 res_valid,
   input  logic [3*COLOR_W-1:0] res_color,
   output logic [COLOR_W-1:0]   pix_r,
   output logic [COLOR_W-1:0]   pix_g,
   output logic [COLOR_W-1:0]   pix_b,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_sof,
   output logic                 pix_eol,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow_err
);

   localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW  = 3 * COLOR_W;

   sched_state_t     state_q;
   sched_state_t     state_nxt;
   logic [CRW-1:0]   credits_q;
   logic [X_W-1:0]   ix_q;
   logic [Y_W-1:0]   iy_q;
   logic [X_W-1:0]   ox_q;
   logic [Y_W-1:0]   oy_q;
   logic             frame_done_q;
   logic             frame_done_nxt;
   logic             overflow_q;
   logic [PW-1:0]    fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             issue_hs_c;
   logic             pop_c;
   logic             issue_last_c;
   logic             out_last_c;
   logic             ox_wrap_c;
   logic             oy_wrap_c;
   logic             ix_wrap_c;
   logic             iy_wrap_c;

   assign issue_valid = (state_q == ST_ISSUE) && (credits_q != '0);
   assign issue_hs_c  = issue_valid & issue_ready;
   assign pop_c       = pix_valid & pix_ready;

   assign ix_wrap_c    = (ix_q == X_W'(SCREEN_W - 1));
   assign iy_wrap_c    = (iy_q == Y_W'(SCREEN_H - 1));
   assign ox_wrap_c    = (ox_q == X_W'(SCREEN_W - 1));
   assign oy_wrap_c    = (oy_q == Y_W'(SCREEN_H - 1));
   assign issue_last_c = issue_hs_c & ix_wrap_c & iy_wrap_c;
   assign out_last_c   = pop_c & ox_wrap_c & oy_wrap_c;

   assign issue_x      = ix_q;
   assign issue_y      = iy_q;
   assign pix_valid    = ~fifo_empty;
   assign pix_r        = fifo_head[PW-1 -: COLOR_W];
   assign pix_g        = fifo_head[2*COLOR_W-1 -: COLOR_W];
   assign pix_b        = fifo_head[COLOR_W-1:0];
   assign pix_sof      = pix_valid & (ox_q == '0) & (oy_q == '0);
   assign pix_eol      = pix_valid & ox_wrap_c;
   assign busy         = (state_q != ST_IDLE);
   assign frame_done   = frame_done_q;
   assign overflow_err = overflow_q;

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk   (out_stream_aclk),
      .rst_n (periph_resetn),
      .push  (res_valid),
      .din   (res_color),
      .pop   (pop_c),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register and registered frame-done pulse.
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state_q      <= ST_IDLE;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         frame_done_q <= frame_done_nxt;
      end
   end

   // Next-state logic; enable is only consulted at frame boundaries.
   always_comb begin
      state_nxt      = state_q;
      frame_done_nxt = 1'b0;
      case (state_q)
         ST_IDLE:  if (enable) state_nxt = ST_ISSUE;
         ST_ISSUE: if (issue_last_c) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (out_last_c) begin
               frame_done_nxt = 1'b1;
               state_nxt      = enable ? ST_ISSUE : ST_IDLE;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Credits track free result slots: returned on pop, consumed on issue.
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn)
         credits_q <= CRW'(FIFO_DEPTH);
      else if (pop_c && !issue_hs_c && (credits_q != CRW'(FIFO_DEPTH)))
         credits_q <= credits_q + CRW'(1);
      else if (issue_hs_c && !pop_c && (credits_q != '0))
         credits_q <= credits_q - CRW'(1);
   end

   // Issue-side raster counter.
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         ix_q <= '0;
         iy_q <= '0;
      end else if (issue_hs_c) begin
         if (ix_wrap_c) begin
            ix_q <= '0;
            iy_q <= iy_wrap_c ? '0 : iy_q + Y_W'(1);
         end else begin
            ix_q <= ix_q + X_W'(1);
         end
      end
   end

   // Output-side raster counter driving SOF/EOL.
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         ox_q <= '0;
         oy_q <= '0;
      end else if (pop_c) begin
         if (ox_wrap_c) begin
            ox_q <= '0;
            oy_q <= oy_wrap_c ? '0 : oy_q + Y_W'(1);
         end else begin
            ox_q <= ox_q + X_W'(1);
         end
      end
   end

   // Sticky flag for a result that found no room in the FIFO.
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn)
         overflow_q <= 1'b0;
      else if (res_valid && fifo_full && !pop_c)
         overflow_q <= 1'b1;
   end

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// Directed bench for ray_pixel_scheduler on a 4x2 raster with a 3-cycle datapath model.
module tb_ray_pixel_scheduler;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = 8;

   typedef struct {
      int x;
      int y;
   } coord_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          issue_ready = 1'b0;
   logic          pix_ready = 1'b0;
   logic          res_valid = 1'b0;
   logic [23:0]   res_color = '0;
   logic [9:0]    issue_x;
   logic [8:0]    issue_y;
   logic          issue_valid;
   logic [7:0]    pix_r, pix_g, pix_b;
   logic          pix_valid, pix_sof, pix_eol, busy, frame_done, overflow_err;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor / model state
   coord_t        exp_q[$];
   coord_t        e;
   int            mx, my;
   int            hs_cnt, pop_cnt, sof_cnt, eol_cnt, fd_cnt;
   logic          fd_pend;
   logic          first_sof;
   logic [18:0]   first_xy;
   logic          dl_v [3];
   logic [23:0]   dl_c [3];
   logic          hs;
   logic          inj = 1'b0;
   logic [23:0]   inj_col = 24'hABCDEF;

   ray_pixel_scheduler #(
      .SCREEN_W   (W),
      .SCREEN_H   (H),
      .FIFO_DEPTH (D),
      .COLOR_W    (CW)
   ) dut (
      .out_stream_aclk (clk),
      .periph_resetn   (rst_n),
      .enable          (enable),
      .issue_x         (issue_x),
      .issue_y         (issue_y),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .res_valid       (res_valid),
      .res_color       (res_color),
      .pix_r           (pix_r),
      .pix_g           (pix_g),
      .pix_b           (pix_b),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_sof         (pix_sof),
      .pix_eol         (pix_eol),
      .busy            (busy),
      .frame_done      (frame_done),
      .overflow_err    (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pix_col(input int x, input int y);
      logic [7:0] r, g, b;
      r = 8'(x * 40 + y * 7 + 1);
      g = 8'(255 - x - y * 16);
      b = 8'(y * 100 + x + 9);
      return {r, g, b};
   endfunction

   // Scoreboard, issue-order model and 3-cycle datapath, all sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mx = 0; my = 0;
         hs_cnt = 0; pop_cnt = 0; sof_cnt = 0; eol_cnt = 0; fd_cnt = 0;
         fd_pend = 1'b0; first_sof = 1'b0; first_xy = '1;
         for (int i = 0; i < 3; i++) begin dl_v[i] = 1'b0; dl_c[i] = '0; end
         res_valid = 1'b0; res_color = '0;
      end else begin
         check_val("frame_done_pulse", 32'(frame_done), 32'(fd_pend));
         fd_pend = 1'b0;
         if (frame_done) fd_cnt++;

         hs = issue_valid & issue_ready;
         if (hs) begin
            check_val("issue_x", 32'(issue_x), 32'(mx));
            check_val("issue_y", 32'(issue_y), 32'(my));
            if (hs_cnt == 0) first_xy = {issue_x, issue_y};
            exp_q.push_back('{x: mx, y: my});
            hs_cnt++;
            if (mx == int'(W) - 1) begin
               mx = 0;
               my = (my == int'(H) - 1) ? 0 : my + 1;
            end else begin
               mx++;
            end
         end

         if (pix_valid & pix_ready) begin
            check_val("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_val("pix_color", {8'h0, pix_r, pix_g, pix_b}, {8'h0, pix_col(e.x, e.y)});
               check_val("pix_sof", 32'(pix_sof), 32'((e.x == 0) && (e.y == 0)));
               check_val("pix_eol", 32'(pix_eol), 32'(e.x == int'(W) - 1));
               if ((e.x == int'(W) - 1) && (e.y == int'(H) - 1)) fd_pend = 1'b1;
            end
            if (pop_cnt == 0) first_sof = pix_sof;
            if (pix_sof) sof_cnt++;
            if (pix_eol) eol_cnt++;
            pop_cnt++;
         end

         res_valid = dl_v[2] | inj;
         res_color = inj ? inj_col : dl_c[2];
         dl_v[2] = dl_v[1]; dl_c[2] = dl_c[1];
         dl_v[1] = dl_v[0]; dl_c[1] = dl_c[0];
         dl_v[0] = hs;      dl_c[0] = pix_col(int'(issue_x), int'(issue_y));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; issue_ready = 1'b0; pix_ready = 1'b0; inj = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic wait_hs(input int n, input string tag);
      int t = 0;
      while (hs_cnt < n && t < 200) begin step(1); t++; end
      check_val(tag, 32'(hs_cnt), 32'(n));
   endtask

   task automatic wait_fd(input int n, input string tag);
      int t = 0;
      while (fd_cnt < n && t < 400) begin step(1); t++; end
      check_val(tag, 32'(fd_cnt), 32'(n));
   endtask

   initial begin
      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_outputs", {25'h0, issue_valid, pix_valid, busy, frame_done, overflow_err, pix_sof, pix_eol}, 32'h0);
      check_val("rst_color", {8'h0, pix_r, pix_g, pix_b}, 32'h0);
      step(2);
      rst_n = 1'b1;
      step(2);
      check_val("idle_busy", 32'(busy), 32'h0);
      check_val("idle_issue_valid", 32'(issue_valid), 32'h0);
      check_val("rst_credits", 32'(dut.credits_q), 32'(D));
      check_val("rst_fifo_count", 32'(dut.u_fifo.count_q), 32'h0);

      // Free-running frame, then back-to-back start of the next one
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b1;
      wait_fd(1, "f1_frame_done");
      check_val("f1_pop_cnt", 32'(pop_cnt), 32'd8);
      check_val("f1_sof_cnt", 32'(sof_cnt), 32'd1);
      check_val("f1_eol_cnt", 32'(eol_cnt), 32'd2);
      step(3);
      check_val("f1_next_frame_busy", 32'(busy), 32'd1);
      check_val("f1_next_frame_issued", 32'(hs_cnt > 8), 32'd1);

      // Output stall exhausts credits
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b0;
      step(20);
      check_val("bp_issue_cnt", 32'(hs_cnt), 32'd4);
      check_val("bp_issue_valid", 32'(issue_valid), 32'd0);
      check_val("bp_credits", 32'(dut.credits_q), 32'd0);
      check_val("bp_fifo_count", 32'(dut.u_fifo.count_q), 32'd4);
      check_val("bp_pix_valid", 32'(pix_valid), 32'd1);
      pix_ready = 1'b1;
      wait_fd(1, "bp_frame_done");
      check_val("bp_pop_cnt", 32'(pop_cnt), 32'd8);

      // Same-cycle issue and pop with two credits left
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b0;
      wait_hs(2, "sim_two_issued");
      issue_ready = 1'b0;
      step(8);
      check_val("sim_credits_before", 32'(dut.credits_q), 32'd2);
      check_val("sim_count_before", 32'(dut.u_fifo.count_q), 32'd2);
      issue_ready = 1'b1; pix_ready = 1'b1;
      step(1);
      issue_ready = 1'b0; pix_ready = 1'b0;
      check_val("sim_credits_after", 32'(dut.credits_q), 32'd2);
      check_val("sim_count_after", 32'(dut.u_fifo.count_q), 32'd1);
      check_val("sim_issue_cnt", 32'(hs_cnt), 32'd3);
      issue_ready = 1'b1; pix_ready = 1'b1;
      wait_fd(1, "sim_frame_done");
      check_val("sim_pop_cnt", 32'(pop_cnt), 32'd8);

      // Enable drops mid-frame
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b1;
      wait_hs(3, "en_pixel2_issued");
      enable = 1'b0;
      wait_fd(1, "en_frame_done");
      step(3);
      check_val("en_pop_cnt", 32'(pop_cnt), 32'd8);
      check_val("en_issue_cnt", 32'(hs_cnt), 32'd8);
      check_val("en_busy", 32'(busy), 32'd0);
      check_val("en_issue_valid", 32'(issue_valid), 32'd0);

      // Asynchronous reset mid-frame
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b1;
      wait_hs(6, "ar_pixel5_issued");
      rst_n = 1'b0;
      #1;
      check_val("ar_outputs", {25'h0, issue_valid, pix_valid, busy, frame_done, overflow_err, pix_sof, pix_eol}, 32'h0);
      check_val("ar_color", {8'h0, pix_r, pix_g, pix_b}, 32'h0);
      check_val("ar_issue_xy", {13'h0, issue_x, issue_y}, 32'h0);
      step(2);
      rst_n = 1'b1;
      wait_fd(1, "ar_frame_done");
      check_val("ar_first_issue", 32'(first_xy), 32'h0);
      check_val("ar_first_sof", 32'(first_sof), 32'd1);
      check_val("ar_pop_cnt", 32'(pop_cnt), 32'd8);

      // Result arrives with the FIFO full and no pop
      do_reset();
      enable = 1'b1; issue_ready = 1'b1; pix_ready = 1'b0;
      step(20);
      check_val("ov_pre_flag", 32'(overflow_err), 32'd0);
      check_val("ov_pre_count", 32'(dut.u_fifo.count_q), 32'd4);
      inj = 1'b1;
      step(1);
      inj = 1'b0;
      step(1);
      check_val("ov_flag", 32'(overflow_err), 32'd1);
      check_val("ov_count", 32'(dut.u_fifo.count_q), 32'd4);
      check_val("ov_head", {8'h0, pix_r, pix_g, pix_b}, {8'h0, pix_col(0, 0)});
      step(5);
      check_val("ov_flag_sticky", 32'(overflow_err), 32'd1);
      enable = 1'b0; pix_ready = 1'b1;
      wait_fd(1, "ov_frame_done");
      check_val("ov_pop_cnt", 32'(pop_cnt), 32'd8);
      check_val("ov_flag_end", 32'(overflow_err), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
